// File: rtl/mem_pkg.sv
// Shared size encodings and address helpers for the LSU data memory.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ROW  = 2'b11;

  // Bits needed to hold v (clogb2(NB_COL-1) gives the offset width).
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int x = v; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  function automatic int size_bytes(input logic [1:0] sz, input int nb_col);
    case (sz)
      SZ_BYTE: return 1;
      SZ_HALF: return 2;
      SZ_WORD: return 4;
      default: return nb_col;
    endcase
  endfunction

  function automatic logic is_aligned(input int ofs, input logic [1:0] sz, input int nb_col);
    return (ofs & (size_bytes(sz, nb_col) - 1)) == 0;
  endfunction

endpackage

// File: rtl/sdp_bank_be.sv
// Simple dual-port single-clock RAM with per-lane write enable and registered read.
module sdp_bank_be
  import mem_pkg::*;
#(
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8,
  parameter int RAM_DEPTH = 512,
  parameter     INIT_FILE = "",
  localparam int AW = clogb2(RAM_DEPTH - 1),
  localparam int DW = NB_COL * COL_WIDTH
) (
  input  logic              i_clk,
  input  logic [NB_COL-1:0] we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [RAM_DEPTH];

  initial for (int r = 0; r < RAM_DEPTH; r++) mem[r] = '0;

  // Read and write on the same edge: the read returns the pre-write row.
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < NB_COL; c++)
      if (we[c]) mem[waddr][c*COL_WIDTH +: COL_WIDTH] <= wdata[c*COL_WIDTH +: COL_WIDTH];
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lsu_data_mem.sv
// LSU data memory: lane masking, same-cycle store forwarding, misalign checks and load extension.
module lsu_data_mem
  import mem_pkg::*;
#(
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8,
  parameter int RAM_DEPTH = 512,
  parameter int READ_LAT  = 1,
  parameter     INIT_FILE = "",
  localparam int DATA_W = NB_COL * COL_WIDTH,
  localparam int OFS_W  = clogb2(NB_COL - 1),
  localparam int ROW_W  = clogb2(RAM_DEPTH - 1),
  localparam int ADDR_W = ROW_W + OFS_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_st_valid,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [1:0]        i_st_size,
  input  logic [DATA_W-1:0] i_st_data,
  input  logic              i_ld_valid,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [1:0]        i_ld_size,
  input  logic              i_ld_unsigned,
  output logic              o_ld_valid,
  output logic [DATA_W-1:0] o_ld_data,
  output logic              o_ld_err,
  output logic              o_st_err
);

  typedef struct packed {
    logic [OFS_W-1:0] ofs;
    logic [1:0]       size;
    logic             uns;
    logic             err;
  } ld_sb_t;

  logic [ROW_W-1:0]  st_row, ld_row;
  logic [OFS_W-1:0]  st_ofs, ld_ofs;
  logic              st_al, ld_al, st_fire, collide;
  logic [NB_COL-1:0] st_mask, st_we, fwd_mask;
  logic [DATA_W-1:0] st_wdata, fwd_data, rd_row, merged, shifted, ext;
  logic [READ_LAT:1] vld_q;
  logic [READ_LAT:0] vld_pipe;
  ld_sb_t            sb;
  int                st_nb, ld_nb;
  logic              sgn;

  assign st_row = i_st_addr[ADDR_W-1:OFS_W];
  assign st_ofs = i_st_addr[OFS_W-1:0];
  assign ld_row = i_ld_addr[ADDR_W-1:OFS_W];
  assign ld_ofs = i_ld_addr[OFS_W-1:0];
  assign st_al  = is_aligned(int'(st_ofs), i_st_size, NB_COL);
  assign ld_al  = is_aligned(int'(ld_ofs), i_ld_size, NB_COL);
  assign st_nb  = size_bytes(i_st_size, NB_COL);

  // Reset gates the write enables so stores during reset never reach the array.
  assign st_fire  = i_st_valid & st_al & i_rst;
  assign st_we    = st_mask & {NB_COL{st_fire}};
  assign st_wdata = i_st_data << (st_ofs * COL_WIDTH);
  assign collide  = st_fire & i_ld_valid & ld_al & (st_row == ld_row);
  assign vld_pipe = {vld_q, i_ld_valid};

  always_comb begin
    st_mask = '0;
    for (int i = 0; i < NB_COL; i++)
      if (i >= int'(st_ofs) && i < int'(st_ofs) + st_nb) st_mask[i] = 1'b1;
  end

  sdp_bank_be #(
    .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .RAM_DEPTH(RAM_DEPTH), .INIT_FILE(INIT_FILE)
  ) u_bank (
    .i_clk(i_clk), .we(st_we), .waddr(st_row), .wdata(st_wdata),
    .re(i_ld_valid), .raddr(ld_row), .rdata(rd_row)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_q    <= '0;
      sb       <= '0;
      fwd_mask <= '0;
      fwd_data <= '0;
      o_st_err <= 1'b0;
    end else begin
      vld_q[1] <= vld_pipe[0];
      for (int s = 2; s <= READ_LAT; s++) vld_q[s] <= vld_pipe[s-1];
      o_st_err <= i_st_valid & ~st_al;
      if (i_ld_valid) begin
        sb       <= '{ofs: ld_ofs, size: i_ld_size, uns: i_ld_unsigned, err: ~ld_al};
        fwd_mask <= collide ? st_mask : '0;
        fwd_data <= st_wdata;
      end
    end
  end

  // Write-first per lane on a same-row collision, then align and extend.
  always_comb begin
    merged = rd_row;
    for (int c = 0; c < NB_COL; c++)
      if (fwd_mask[c]) merged[c*COL_WIDTH +: COL_WIDTH] = fwd_data[c*COL_WIDTH +: COL_WIDTH];
    shifted = merged >> (sb.ofs * COL_WIDTH);
    ld_nb   = size_bytes(sb.size, NB_COL);
    sgn     = 1'b0;
    for (int c = 0; c < NB_COL; c++)
      if (c == ld_nb - 1) sgn = shifted[c*COL_WIDTH + COL_WIDTH - 1];
    sgn = sgn & ~sb.uns & (sb.size != SZ_ROW);
    ext = '0;
    for (int c = 0; c < NB_COL; c++)
      ext[c*COL_WIDTH +: COL_WIDTH] = (c < ld_nb) ? shifted[c*COL_WIDTH +: COL_WIDTH]
                                                  : {COL_WIDTH{sgn}};
    if (sb.err) ext = '0;
  end

  if (READ_LAT == 1) begin : g_lat1
    assign o_ld_valid = vld_pipe[1];
    assign o_ld_data  = vld_pipe[1] ? ext : '0;
    assign o_ld_err   = vld_pipe[1] & sb.err;
  end else begin : g_lat2
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        o_ld_data <= '0;
        o_ld_err  <= 1'b0;
      end else begin
        o_ld_data <= vld_pipe[1] ? ext : '0;
        o_ld_err  <= vld_pipe[1] & sb.err;
      end
    end
    assign o_ld_valid = vld_pipe[READ_LAT];
  end

endmodule

// File: tb/tb_lsu_data_mem.sv
// Directed bench: READ_LAT=1 instance for function checks, READ_LAT=2 instance for latency/reset.
module tb_lsu_data_mem;

  logic        clk;
  logic        rst, rst2;
  // READ_LAT = 1 instance
  logic        st_valid, ld_valid, ld_uns;
  logic [10:0] st_addr, ld_addr;
  logic [1:0]  st_size, ld_size;
  logic [31:0] st_data;
  logic        o_ld_valid, o_ld_err, o_st_err;
  logic [31:0] o_ld_data;
  // READ_LAT = 2 instance
  logic        b_st_valid, b_ld_valid, b_ld_uns;
  logic [10:0] b_st_addr, b_ld_addr;
  logic [1:0]  b_st_size, b_ld_size;
  logic [31:0] b_st_data;
  logic        b_ld_valid_o, b_ld_err, b_st_err;
  logic [31:0] b_ld_data;

  int n_assert = 0;
  int n_fail   = 0;

  lsu_data_mem #(.READ_LAT(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_st_valid(st_valid), .i_st_addr(st_addr), .i_st_size(st_size), .i_st_data(st_data),
    .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .i_ld_size(ld_size), .i_ld_unsigned(ld_uns),
    .o_ld_valid(o_ld_valid), .o_ld_data(o_ld_data), .o_ld_err(o_ld_err), .o_st_err(o_st_err)
  );

  lsu_data_mem #(.READ_LAT(2)) dut2 (
    .i_clk(clk), .i_rst(rst2),
    .i_st_valid(b_st_valid), .i_st_addr(b_st_addr), .i_st_size(b_st_size), .i_st_data(b_st_data),
    .i_ld_valid(b_ld_valid), .i_ld_addr(b_ld_addr), .i_ld_size(b_ld_size), .i_ld_unsigned(b_ld_uns),
    .o_ld_valid(b_ld_valid_o), .o_ld_data(b_ld_data), .o_ld_err(b_ld_err), .o_st_err(b_st_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic store(input logic [10:0] a, input logic [1:0] sz, input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_size = sz; st_data = d;
    step();
    st_valid = 1'b0;
  endtask

  task automatic load(input logic [10:0] a, input logic [1:0] sz, input logic uns);
    ld_valid = 1'b1; ld_addr = a; ld_size = sz; ld_uns = uns;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic chk_ld(input string tag, input logic [31:0] d, input logic e);
    chk({tag, ".valid"}, {31'd0, o_ld_valid}, 32'd1);
    chk({tag, ".data"}, o_ld_data, d);
    chk({tag, ".err"}, {31'd0, o_ld_err}, {31'd0, e});
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0;
    st_valid = 0; st_addr = '0; st_size = '0; st_data = '0;
    ld_valid = 0; ld_addr = '0; ld_size = '0; ld_uns = 0;
    b_st_valid = 0; b_st_addr = '0; b_st_size = '0; b_st_data = '0;
    b_ld_valid = 0; b_ld_addr = '0; b_ld_size = '0; b_ld_uns = 0;
    @(negedge clk);
    step();
    // Reset state, plus stores presented during reset must be ignored
    chk("rst.ld_valid", {31'd0, o_ld_valid}, 32'd0);
    chk("rst.ld_data", o_ld_data, 32'd0);
    chk("rst.ld_err", {31'd0, o_ld_err}, 32'd0);
    chk("rst.st_err", {31'd0, o_st_err}, 32'd0);
    store(11'h020, 2'b10, 32'hAAAA_AAAA);
    store(11'h012, 2'b10, 32'h1111_1111);
    chk("rst.st_err_held", {31'd0, o_st_err}, 32'd0);
    rst = 1'b1; rst2 = 1'b1;
    step();
    load(11'h020, 2'b10, 1'b0);
    chk_ld("rst.store_suppressed", 32'h0000_0000, 1'b0);

    // 1: store word then load word one cycle later
    store(11'h010, 2'b10, 32'hDEAD_BEEF);
    chk("t1.st_err", {31'd0, o_st_err}, 32'd0);
    chk("t1.pre_valid", {31'd0, o_ld_valid}, 32'd0);
    load(11'h010, 2'b10, 1'b0);
    chk_ld("t1.ld_word", 32'hDEAD_BEEF, 1'b0);
    step();
    chk("t1.valid_pulse", {31'd0, o_ld_valid}, 32'd0);
    chk("t1.data_idle", o_ld_data, 32'd0);

    // 2: sub-word loads with sign/zero extension
    load(11'h013, 2'b00, 1'b0);
    chk_ld("t2.byte_s", 32'hFFFF_FFDE, 1'b0);
    load(11'h013, 2'b00, 1'b1);
    chk_ld("t2.byte_u", 32'h0000_00DE, 1'b0);
    load(11'h012, 2'b01, 1'b0);
    chk_ld("t2.half_s", 32'hFFFF_DEAD, 1'b0);
    load(11'h010, 2'b00, 1'b0);
    chk_ld("t2.byte_s_low", 32'hFFFF_FFEF, 1'b0);

    // 3: byte store only touches lane 1
    store(11'h011, 2'b00, 32'h0000_0055);
    load(11'h010, 2'b10, 1'b0);
    chk_ld("t3.byte_merge", 32'hDEAD_55EF, 1'b0);

    // 4: same-cycle store/load collision forwards the new lanes
    st_valid = 1'b1; st_addr = 11'h010; st_size = 2'b01; st_data = 32'h0000_1234;
    ld_valid = 1'b1; ld_addr = 11'h010; ld_size = 2'b10; ld_uns = 1'b0;
    step();
    st_valid = 1'b0; ld_valid = 1'b0;
    chk_ld("t4.forward", 32'hDEAD_1234, 1'b0);
    load(11'h010, 2'b10, 1'b0);
    chk_ld("t4.after", 32'hDEAD_1234, 1'b0);
    load(11'h010, 2'b01, 1'b1);
    chk_ld("t4.half_u", 32'h0000_1234, 1'b0);
    load(11'h012, 2'b00, 1'b0);
    chk_ld("t4.byte_s_ad", 32'hFFFF_FFAD, 1'b0);
    load(11'h010, 2'b11, 1'b0);
    chk_ld("t4.row_noext", 32'hDEAD_1234, 1'b0);

    // 5: misaligned store and load
    store(11'h012, 2'b10, 32'hCAFE_F00D);
    chk("t5.st_err", {31'd0, o_st_err}, 32'd1);
    step();
    chk("t5.st_err_pulse", {31'd0, o_st_err}, 32'd0);
    load(11'h010, 2'b10, 1'b0);
    chk_ld("t5.row_unchanged", 32'hDEAD_1234, 1'b0);
    load(11'h011, 2'b01, 1'b0);
    chk_ld("t5.ld_misalign", 32'h0000_0000, 1'b1);

    // 6: READ_LAT=2 latency and in-flight drop on reset
    b_st_valid = 1'b1; b_st_addr = 11'h010; b_st_size = 2'b10; b_st_data = 32'hDEAD_1234;
    step();
    b_st_valid = 1'b0;
    b_ld_valid = 1'b1; b_ld_addr = 11'h010; b_ld_size = 2'b10; b_ld_uns = 1'b0;
    step();
    b_ld_valid = 1'b0;
    chk("t6.lat_cycle1", {31'd0, b_ld_valid_o}, 32'd0);
    step();
    chk("t6.lat_cycle2", {31'd0, b_ld_valid_o}, 32'd1);
    chk("t6.lat_data", b_ld_data, 32'hDEAD_1234);
    chk("t6.lat_err", {31'd0, b_ld_err}, 32'd0);
    step();
    chk("t6.lat_pulse", {31'd0, b_ld_valid_o}, 32'd0);

    b_ld_valid = 1'b1;
    step();
    b_ld_valid = 1'b0;
    rst2 = 1'b0;
    b_st_valid = 1'b1; b_st_addr = 11'h010; b_st_size = 2'b10; b_st_data = 32'hFFFF_FFFF;
    step();
    b_st_valid = 1'b0;
    chk("t6.rst_valid", {31'd0, b_ld_valid_o}, 32'd0);
    chk("t6.rst_data", b_ld_data, 32'd0);
    chk("t6.rst_err", {31'd0, b_ld_err}, 32'd0);
    chk("t6.rst_st_err", {31'd0, b_st_err}, 32'd0);
    rst2 = 1'b1;
    step();
    chk("t6.dropped", {31'd0, b_ld_valid_o}, 32'd0);
    b_ld_valid = 1'b1;
    step();
    b_ld_valid = 1'b0;
    step();
    chk("t6.retained_valid", {31'd0, b_ld_valid_o}, 32'd1);
    chk("t6.retained_data", b_ld_data, 32'hDEAD_1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
